counter_host: RTL and testbench



---
 rtl/counter_pkg.sv | 26 ++
 rtl/counter_host.sv | 147 ++++++++++++++
 tb/tb_counter_host.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter pin-interface host: state encoding,
// command op codes and the sizing helper for the internal cycle counter.
package counter_pkg;

    localparam int WIDTH_DEFAULT = 8;

    localparam logic OP_READ = 1'b0;
    localparam logic OP_LOAD = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        L_SETUP,
        L_LOW,
        L_HOLD,
        R_EN,
        RSP
    } hostState_e;

    // Bits needed to hold the longest per-state cycle count without wrapping.
    function automatic int cycleCountWidth(input int lowCycles, input int turnCycles);
        int longest;
        longest = (lowCycles > turnCycles + 1) ? lowCycles : (turnCycles + 1);
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/counter_host.sv
// Host-side sequencer for the loadable counter's pin interface. It turns
// valid/ready LOAD and READ commands into load_n / oe_n / shared-bus pin
// sequences and returns READ samples on a valid/ready response port.
// The bus is never driven by the host while the counter may be driving it.
module counter_host
    import counter_pkg::*;
#(
    parameter int WIDTH             = WIDTH_DEFAULT,
    parameter int LOAD_LOW_CYCLES   = 2,
    parameter int TURNAROUND_CYCLES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic             i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_data,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_data,
    output logic             o_load_n,
    output logic             o_oe_n,
    output logic [WIDTH-1:0] o_bus_out,
    output logic             o_bus_oe,
    input  logic [WIDTH-1:0] i_bus_in,
    output logic             o_busy
);

    localparam int CNT_W = cycleCountWidth(LOAD_LOW_CYCLES, TURNAROUND_CYCLES);
    localparam logic [CNT_W-1:0] LOW_RELOAD  = CNT_W'(LOAD_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_RELOAD = CNT_W'(TURNAROUND_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    hostState_e       r_state;
    hostState_e       w_nextState;
    logic [CNT_W-1:0] r_cycleCnt;
    logic [CNT_W-1:0] w_nextCycleCnt;
    logic             r_loadN;
    logic             w_nextLoadN;
    logic             r_oeN;
    logic             w_nextOeN;
    logic             r_busOe;
    logic             w_nextBusOe;
    logic [WIDTH-1:0] r_busOut;
    logic [WIDTH-1:0] w_nextBusOut;
    logic             r_rspValid;
    logic             w_nextRspValid;
    logic [WIDTH-1:0] r_rspData;
    logic [WIDTH-1:0] w_nextRspData;

    // Register state, cycle counter and every pin/response output; reset aborts any operation.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cycleCnt <= '0;
            r_loadN    <= 1'b1;
            r_oeN      <= 1'b1;
            r_busOe    <= 1'b0;
            r_busOut   <= '0;
            r_rspValid <= 1'b0;
            r_rspData  <= '0;
        end else begin
            r_state    <= w_nextState;
            r_cycleCnt <= w_nextCycleCnt;
            r_loadN    <= w_nextLoadN;
            r_oeN      <= w_nextOeN;
            r_busOe    <= w_nextBusOe;
            r_busOut   <= w_nextBusOut;
            r_rspValid <= w_nextRspValid;
            r_rspData  <= w_nextRspData;
        end
    end

    // Next state plus the pin values for that state, so registered pins line up with the state.
    always_comb begin
        w_nextState    = r_state;
        w_nextCycleCnt = r_cycleCnt;
        w_nextLoadN    = 1'b1;
        w_nextOeN      = 1'b1;
        w_nextBusOe    = 1'b0;
        w_nextBusOut   = r_busOut;
        w_nextRspValid = r_rspValid;
        w_nextRspData  = r_rspData;
        case (r_state)
            IDLE: begin
                if (i_cmd_valid) begin
                    if (i_cmd_op == OP_LOAD) begin
                        w_nextState  = L_SETUP;
                        w_nextBusOe  = 1'b1;
                        w_nextBusOut = i_cmd_data;
                    end else begin
                        w_nextState    = R_EN;
                        w_nextOeN      = 1'b0;
                        w_nextCycleCnt = TURN_RELOAD;
                    end
                end
            end
            L_SETUP: begin
                w_nextState    = L_LOW;
                w_nextLoadN    = 1'b0;
                w_nextBusOe    = 1'b1;
                w_nextCycleCnt = LOW_RELOAD;
            end
            L_LOW: begin
                w_nextBusOe = 1'b1;
                if (r_cycleCnt == '0) begin
                    w_nextState = L_HOLD;
                end else begin
                    w_nextLoadN    = 1'b0;
                    w_nextCycleCnt = r_cycleCnt - CNT_ONE;
                end
            end
            L_HOLD: begin
                w_nextState = IDLE;
            end
            R_EN: begin
                if (r_cycleCnt == '0) begin
                    w_nextState    = RSP;
                    w_nextRspValid = 1'b1;
                    w_nextRspData  = i_bus_in;
                end else begin
                    w_nextOeN      = 1'b0;
                    w_nextCycleCnt = r_cycleCnt - CNT_ONE;
                end
            end
            RSP: begin
                if (i_rsp_ready) begin
                    w_nextRspValid = 1'b0;
                    w_nextState    = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign o_cmd_ready = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_rsp_valid = r_rspValid;
    assign o_rsp_data  = r_rspData;
    assign o_load_n    = r_loadN;
    assign o_oe_n      = r_oeN;
    assign o_bus_out   = r_busOut;
    assign o_bus_oe    = r_busOe;

endmodule

// File: tb/tb_counter_host.sv
// Directed and mixed-command bench for counter_host, driving it against a
// behavioural model of the loadable counter's pins.
module tb_counter_host;
    import counter_pkg::*;

    logic       clk;
    logic       rst;
    logic       cmdValid;
    logic       cmdReady;
    logic       cmdOp;
    logic [7:0] cmdData;
    logic       rspValid;
    logic       rspReady;
    logic [7:0] rspData;
    logic       loadN;
    logic       oeN;
    logic [7:0] busOut;
    logic       busOe;
    logic [7:0] busIn;
    logic       busy;

    int total = 0;
    int bad = 0;
    int rspCount = 0;
    bit monitorsOn = 0;
    logic prevRspValid = 1'b0;

    logic [7:0] modelCnt;
    logic [7:0] edgeSample;
    logic       prevLoadN;
    logic [7:0] uioBus;

    counter_host #(
        .WIDTH(8),
        .LOAD_LOW_CYCLES(2),
        .TURNAROUND_CYCLES(1)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_cmd_valid(cmdValid),
        .o_cmd_ready(cmdReady),
        .i_cmd_op(cmdOp),
        .i_cmd_data(cmdData),
        .o_rsp_valid(rspValid),
        .i_rsp_ready(rspReady),
        .o_rsp_data(rspData),
        .o_load_n(loadN),
        .o_oe_n(oeN),
        .o_bus_out(busOut),
        .o_bus_oe(busOe),
        .i_bus_in(busIn),
        .o_busy(busy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared uio wires: host drives when enabled, counter drives while oe_n is low.
    assign uioBus = busOe ? busOut : 8'h00;
    assign busIn  = (!oeN) ? modelCnt : 8'h00;

    // Counter model: shares the chip reset, loads on the first edge it sees load_n low,
    // otherwise counts every clock. edgeSample keeps the value it was showing before the edge.
    always @(posedge clk) begin
        edgeSample <= modelCnt;
        if (rst) begin
            modelCnt  <= 8'h00;
            prevLoadN <= 1'b1;
        end else begin
            if (!loadN && prevLoadN) modelCnt <= uioBus;
            else                     modelCnt <= modelCnt + 8'h01;
            prevLoadN <= loadN;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Offer one command from a falling edge and return on the falling edge after it is taken.
    task automatic applyStimulus(input logic op, input logic [7:0] data);
        int waitCycles;
        waitCycles = 0;
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdData  = data;
        while (!cmdReady && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("cmdAccepted", cmdReady, 1);
        @(negedge clk);
        cmdValid = 1'b0;
    endtask

    // Continuous pin-safety checks and read-value scoreboard on every falling edge.
    always @(negedge clk) begin
        if (monitorsOn && !rst) begin
            checkOutput("busContention", busOe && !oeN, 0);
            checkOutput("loadDuringOe", !loadN && !oeN, 0);
            if (rspValid && !prevRspValid) begin
                checkOutput("readValue", rspData, edgeSample);
                rspCount++;
            end
        end
        prevRspValid = rspValid;
    end

    // Hard stop in case something wedges beyond every bounded wait.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int waitCycles;
        int baseRsp;
        int readsIssued;
        logic rndOp;
        logic [7:0] rndData;

        rst = 1'b1;
        cmdValid = 1'b0;
        cmdOp = OP_READ;
        cmdData = 8'h00;
        rspReady = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rstLoadN", loadN, 1);
        checkOutput("rstOeN", oeN, 1);
        checkOutput("rstBusOe", busOe, 0);
        checkOutput("rstBusOut", busOut, 8'h00);
        checkOutput("rstRspValid", rspValid, 0);
        checkOutput("rstRspData", rspData, 8'h00);
        checkOutput("rstBusy", busy, 0);
        rst = 1'b0;
        monitorsOn = 1;

        $display("[TB] idle after reset");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idleLoadN", loadN, 1);
            checkOutput("idleOeN", oeN, 1);
            checkOutput("idleBusOe", busOe, 0);
            checkOutput("idleRspValid", rspValid, 0);
            checkOutput("idleCmdReady", cmdReady, 1);
        end

        $display("[TB] LOAD 0x40 then back-to-back READ");
        cmdValid = 1'b1; cmdOp = OP_LOAD; cmdData = 8'h40;
        @(negedge clk);
        cmdValid = 1'b0;
        checkOutput("t0LoadN", loadN, 1);
        checkOutput("t0BusOe", busOe, 1);
        checkOutput("t0BusOut", busOut, 8'h40);
        checkOutput("t0CmdReady", cmdReady, 0);
        @(negedge clk);
        checkOutput("t1LoadN", loadN, 0);
        checkOutput("t1BusOe", busOe, 1);
        @(negedge clk);
        checkOutput("t2LoadN", loadN, 0);
        checkOutput("t2BusOut", busOut, 8'h40);
        checkOutput("t2ModelCnt", modelCnt, 8'h40);
        @(negedge clk);
        checkOutput("t3LoadN", loadN, 1);
        checkOutput("t3BusOe", busOe, 1);
        @(negedge clk);
        checkOutput("t4BusOe", busOe, 0);
        checkOutput("t4CmdReady", cmdReady, 1);
        cmdValid = 1'b1; cmdOp = OP_READ; rspReady = 1'b1;
        @(negedge clk);
        cmdValid = 1'b0;
        checkOutput("t5OeN", oeN, 0);
        checkOutput("t5BusOe", busOe, 0);
        @(negedge clk);
        checkOutput("t6OeN", oeN, 0);
        checkOutput("t6RspValid", rspValid, 0);
        @(negedge clk);
        checkOutput("t7RspValid", rspValid, 1);
        checkOutput("t7RspData", rspData, 8'h44);
        checkOutput("t7OeN", oeN, 1);
        @(negedge clk);
        checkOutput("t8RspValid", rspValid, 0);
        checkOutput("t8CmdReady", cmdReady, 1);

        $display("[TB] READ with response back-pressure");
        cmdValid = 1'b1; cmdOp = OP_READ; rspReady = 1'b0;
        @(negedge clk);
        cmdValid = 1'b0;
        checkOutput("t9OeN", oeN, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t11RspValid", rspValid, 1);
        checkOutput("t11RspData", rspData, 8'h48);
        cmdValid = 1'b1; cmdOp = OP_READ;
        for (int i = 0; i < 5; i++) begin
            checkOutput("holdRspValid", rspValid, 1);
            checkOutput("holdRspData", rspData, 8'h48);
            checkOutput("holdOeN", oeN, 1);
            checkOutput("holdCmdReady", cmdReady, 0);
            @(negedge clk);
        end
        rspReady = 1'b1;
        @(negedge clk);
        checkOutput("t17RspValid", rspValid, 0);
        checkOutput("t17Busy", busy, 0);
        checkOutput("t17CmdReady", cmdReady, 1);
        @(negedge clk);
        cmdValid = 1'b0;
        checkOutput("t18Busy", busy, 1);
        checkOutput("t18OeN", oeN, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t20RspValid", rspValid, 1);
        checkOutput("t20RspData", rspData, 8'h51);
        @(negedge clk);
        checkOutput("t21RspValid", rspValid, 0);

        $display("[TB] reset during load_n low");
        cmdValid = 1'b1; cmdOp = OP_LOAD; cmdData = 8'hA5;
        @(negedge clk);
        cmdValid = 1'b0;
        @(negedge clk);
        checkOutput("abortPreLoadN", loadN, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortLoadN", loadN, 1);
        checkOutput("abortBusOe", busOe, 0);
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortCmdReady", cmdReady, 1);
        checkOutput("abortModelCnt", modelCnt, 8'h00);
        cmdValid = 1'b1; cmdOp = OP_READ; rspReady = 1'b1;
        @(negedge clk);
        cmdValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abortReadValid", rspValid, 1);
        checkOutput("abortReadData", rspData, 8'h02);
        @(negedge clk);

        $display("[TB] mixed command sequence");
        baseRsp = rspCount;
        readsIssued = 0;
        for (int n = 0; n < 500; n++) begin
            rndOp   = 1'($urandom_range(0, 1));
            rndData = 8'($urandom);
            rspReady = 1'b0;
            applyStimulus(rndOp, rndData);
            if (rndOp == OP_READ) begin
                readsIssued++;
                waitCycles = 0;
                while (!rspValid && waitCycles < 20) begin
                    @(negedge clk);
                    waitCycles++;
                end
                checkOutput("rspArrived", rspValid, 1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                rspReady = 1'b1;
                @(negedge clk);
                rspReady = 1'b0;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        checkOutput("readCount", rspCount - baseRsp, readsIssued);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
